// File: rtl/matmul3_seq_engine.sv
// Sequential 3x3 unsigned matrix multiply, C = A x B, one multiply-accumulate per clock.
// Operands are snapshotted at start; c is loaded all at once when the last element completes.
module matmul3_seq_engine #(
    parameter int INT_WIDTH = 8,
    parameter int DIM       = 3,
    parameter int ACC_WIDTH = 18,
    parameter bit SATURATE  = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [DIM*DIM*INT_WIDTH-1:0]   a,
    input  logic [DIM*DIM*INT_WIDTH-1:0]   b,
    output logic [DIM*DIM*INT_WIDTH-1:0]   c,
    output logic                           done,
    output logic                           busy
);
    localparam int MW = DIM*DIM*INT_WIDTH;
    localparam int PW = 2*INT_WIDTH;
    localparam logic [ACC_WIDTH-1:0] EL_MAX = ACC_WIDTH'((1 << INT_WIDTH) - 1);
    localparam logic [1:0] LAST = 2'(DIM - 1);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                state, state_d;
    logic [MW-1:0]         a_q, b_q, work, work_nx;
    logic [ACC_WIDTH-1:0]  acc, sum;
    logic [1:0]            i, j, k;
    logic [INT_WIDTH-1:0]  a_el, b_el, res, sat_val;
    logic [PW-1:0]         prod;
    logic                  k_wrap, last_elem;

    // Datapath for the current MAC step and the element it may complete
    always_comb begin
        a_el      = a_q[(int'(i)*DIM + int'(k))*INT_WIDTH +: INT_WIDTH];
        b_el      = b_q[(int'(k)*DIM + int'(j))*INT_WIDTH +: INT_WIDTH];
        prod      = PW'(a_el) * PW'(b_el);
        sum       = acc + ACC_WIDTH'(prod);
        sat_val   = (sum > EL_MAX) ? {INT_WIDTH{1'b1}} : sum[INT_WIDTH-1:0];
        res       = SATURATE ? sat_val : sum[INT_WIDTH-1:0];
        k_wrap    = (k == LAST);
        last_elem = k_wrap && (i == LAST) && (j == LAST);
        work_nx   = work;
        if (k_wrap)
            work_nx[(int'(i)*DIM + int'(j))*INT_WIDTH +: INT_WIDTH] = res;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (enable) state_d = MAC;
            MAC:     if (!enable) state_d = IDLE;
                     else if (last_elem) state_d = DONE;
            DONE:    if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            work <= '0;
            acc  <= '0;
            i    <= '0;
            j    <= '0;
            k    <= '0;
            c    <= '0;
            done <= 1'b0;
            busy <= 1'b0;
        end else begin
            case (state)
                IDLE: if (enable) begin
                    a_q  <= a;
                    b_q  <= b;
                    acc  <= '0;
                    i    <= '0;
                    j    <= '0;
                    k    <= '0;
                    busy <= 1'b1;
                end
                MAC: if (!enable) begin
                    // abort: partial work is simply overwritten by the next run
                    busy <= 1'b0;
                end else begin
                    work <= work_nx;
                    if (k_wrap) begin
                        acc <= '0;
                        k   <= '0;
                        if (j == LAST) begin
                            j <= '0;
                            i <= (i == LAST) ? 2'd0 : i + 2'd1;
                        end else begin
                            j <= j + 2'd1;
                        end
                    end else begin
                        acc <= sum;
                        k   <= k + 2'd1;
                    end
                    if (last_elem) begin
                        c    <= work_nx;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                DONE: if (!enable) done <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul3_seq_engine.sv
// Randomized and directed bench for matmul3_seq_engine; truncating and saturating
// instances share stimulus and are checked against a plain-arithmetic matrix product.
module tb_matmul3_seq_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [71:0] a = '0, b = '0;
    logic [71:0] c, c_sat;
    logic        done, busy, done_sat, busy_sat;
    int checks = 0;
    int errors = 0;

    matmul3_seq_engine #(.SATURATE(1'b0)) dut (
        .clk(clk), .rst(rst), .enable(enable), .a(a), .b(b),
        .c(c), .done(done), .busy(busy));

    matmul3_seq_engine #(.SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .enable(enable), .a(a), .b(b),
        .c(c_sat), .done(done_sat), .busy(busy_sat));

    always #5 clk = ~clk;

    function automatic logic [71:0] model(input logic [71:0] ma, input logic [71:0] mb, input bit sat);
        logic [71:0] r;
        int s;
        r = '0;
        for (int ri = 0; ri < 3; ri++)
            for (int cj = 0; cj < 3; cj++) begin
                s = 0;
                for (int kk = 0; kk < 3; kk++)
                    s += int'(ma[(ri*3+kk)*8 +: 8]) * int'(mb[(kk*3+cj)*8 +: 8]);
                if (sat && s > 255) r[(ri*3+cj)*8 +: 8] = 8'hFF;
                else r[(ri*3+cj)*8 +: 8] = s[7:0];
            end
        return r;
    endfunction

    function automatic logic [71:0] seq19();
        logic [71:0] r;
        for (int n = 0; n < 9; n++) r[n*8 +: 8] = 8'(n + 1);
        return r;
    endfunction

    function automatic logic [71:0] ident();
        logic [71:0] r;
        r = '0;
        for (int n = 0; n < 3; n++) r[(n*4)*8 +: 8] = 8'd1;
        return r;
    endfunction

    // start edge samples enable in IDLE; afterwards we sit 1 time unit past that edge
    task automatic start(input logic [71:0] ma, input logic [71:0] mb);
        @(negedge clk);
        a = ma; b = mb; enable = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drop();
        enable = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        checks++;
        if (c !== 72'h0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: c=%h done=%b busy=%b, want c=0 done=0 busy=0", c, done, busy);
        end
        @(negedge clk); rst = 1'b0;
        step(1);
    endtask

    task automatic test_identity();
        logic [71:0] exp;
        exp = seq19();
        start(seq19(), ident());
        step(26);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL identity_edge26: done=%b busy=%b, want done=0 busy=1", done, busy);
        end
        step(1);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || c !== exp) begin
            errors++;
            $display("FAIL identity_edge27: done=%b busy=%b c=%h, want 1 0 %h", done, busy, c, exp);
        end
        drop();
    endtask

    task automatic test_row_sums();
        logic [71:0] exp;
        exp = {8'd24, 8'd24, 8'd24, 8'd15, 8'd15, 8'd15, 8'd6, 8'd6, 8'd6};
        start(seq19(), {9{8'h01}});
        step(27);
        checks++;
        if (done !== 1'b1 || c !== exp) begin
            errors++;
            $display("FAIL row_sums: done=%b c=%h, want 1 %h", done, c, exp);
        end
        step(2);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_hold: done=%b, want 1 while enable high", done);
        end
        drop();
        checks++;
        if (done !== 1'b0 || c !== exp) begin
            errors++;
            $display("FAIL row_sums_drop: done=%b c=%h, want 0 %h", done, c, exp);
        end
    endtask

    task automatic test_overflow();
        start({9{8'hFF}}, {9{8'hFF}});
        step(27);
        checks++;
        if (c !== {9{8'h03}} || done !== 1'b1) begin
            errors++;
            $display("FAIL overflow_trunc: c=%h done=%b, want %h 1", c, done, {9{8'h03}});
        end
        checks++;
        if (c_sat !== {9{8'hFF}} || done_sat !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sat: c=%h done=%b, want %h 1", c_sat, done_sat, {9{8'hFF}});
        end
        drop();
    endtask

    task automatic test_snapshot();
        start(seq19(), ident());
        step(4);
        a = '0;
        step(23);
        checks++;
        if (done !== 1'b1 || c !== seq19()) begin
            errors++;
            $display("FAIL snapshot: done=%b c=%h, want 1 %h", done, c, seq19());
        end
        drop();
    endtask

    task automatic test_abort();
        logic [71:0] prev;
        int rose;
        prev = c;
        rose = 0;
        start({9{8'h02}}, {9{8'h02}});
        step(9);
        drop();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || c !== prev) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b c=%h, want 0 0 %h", busy, done, c, prev);
        end
        for (int n = 0; n < 30; n++) begin
            step(1);
            if (done !== 1'b0 || c !== prev) rose++;
        end
        checks++;
        if (rose != 0) begin
            errors++;
            $display("FAIL abort_idle: %0d cycles with done/c changed, want 0", rose);
        end
        start({9{8'h02}}, {9{8'h02}});
        step(26);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL abort_rerun_early: done=%b at edge 26, want 0", done);
        end
        step(1);
        checks++;
        if (done !== 1'b1 || c !== {9{8'd12}}) begin
            errors++;
            $display("FAIL abort_rerun: done=%b c=%h, want 1 %h", done, c, {9{8'd12}});
        end
        drop();
    endtask

    task automatic test_async_reset();
        start({9{8'h03}}, ident());
        step(8);
        checks++;
        if (busy !== 1'b1 || c === 72'h0) begin
            errors++;
            $display("FAIL async_pre: busy=%b c=%h, want busy=1 c nonzero", busy, c);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (c !== 72'h0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: c=%h done=%b busy=%b, want 0 0 0", c, done, busy);
        end
        #1 rst = 1'b0; enable = 1'b0;
        step(2);
        start(seq19(), ident());
        step(27);
        checks++;
        if (done !== 1'b1 || c !== seq19()) begin
            errors++;
            $display("FAIL async_rerun: done=%b c=%h, want 1 %h", done, c, seq19());
        end
        drop();
    endtask

    task automatic test_random();
        logic [71:0] ra, rb, et, es;
        for (int n = 0; n < 6; n++) begin
            ra = {$urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom};
            if (n == 5) ra = {9{8'hFF}};
            et = model(ra, rb, 1'b0);
            es = model(ra, rb, 1'b1);
            start(ra, rb);
            step(27);
            checks++;
            if (done !== 1'b1 || c !== et) begin
                errors++;
                $display("FAIL random_trunc[%0d]: done=%b c=%h, want 1 %h", n, done, c, et);
            end
            checks++;
            if (done_sat !== 1'b1 || c_sat !== es) begin
                errors++;
                $display("FAIL random_sat[%0d]: done=%b c=%h, want 1 %h", n, done_sat, c_sat, es);
            end
            drop();
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_row_sums();
        test_overflow();
        test_snapshot();
        test_abort();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
